mem_latency_model: RTL and testbench

- Parametrised bus-slave memory model for CPU benches; successor to the fixed test RAM plus instruction-injection mux.
- Responds to read/write/bwe requests with programmable wait-request stalls and in-order pipelined read returns (multiple reads outstanding).
- Supports per-request data injection, so randomly generated instructions can be returned in place of memory contents.
- Sits between the CPU bus port and the bench stimulus; synthesizable RTL.

---
 rtl/mem_latency_model_pkg.sv | 20 ++
 rtl/mem_latency_model_read_return_fifo.sv | 75 +++++++
 rtl/mem_latency_model.sv | 176 +++++++++++++++++
 tb/tb_mem_latency_model.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_latency_model_pkg.sv
// Shared types for the memory latency model: FSM state encoding and lane helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Read-return entries are {data, age}; their widths depend on per-instance
// parameters, so the entry struct is declared inside read_return_fifo.
package memModelPkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_e;

    localparam int BYTE_W = 8;

    // Number of byte lanes on a data bus of the given width.
    function automatic int bytes_per_word(input int data_width);
        return data_width / BYTE_W;
    endfunction

endpackage

// File: rtl/mem_latency_model_read_return_fifo.sv
// Circular FIFO of read-return entries; every stored age counts down once per cycle.
// Latency: head_vld is high when the head entry's age has reached zero.
// Backpressure: the caller must not push while full; pop only while head_vld.
// Ports: clk/rst, push + push_data/push_age, pop, head_vld/head_data, full, empty, count.
module read_return_fifo
    import memModelPkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int LATENCY_WIDTH   = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic [LATENCY_WIDTH-1:0]      push_age,
    input  logic                          pop,
    output logic                          head_vld,
    output logic [DATA_WIDTH-1:0]         head_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(MAX_OUTSTANDING):0] count
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    data;
        logic [LATENCY_WIDTH-1:0] age;
    } read_entry_t;

    read_entry_t [MAX_OUTSTANDING-1:0] entry_q, entry_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        entry_d = entry_q;
        // Ages saturate at zero; free slots decrement too, which is harmless
        // because a push overwrites the whole entry.
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (entry_q[i].age != '0) begin
                entry_d[i].age = entry_q[i].age - LATENCY_WIDTH'(1);
            end
        end
        if (push) begin
            entry_d[wr_ptr_q] = '{data: push_data, age: push_age};
        end
        // Depth is a power of two, so pointers wrap naturally.
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            entry_q  <= entry_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign count     = count_q;
    assign head_vld  = !empty && (entry_q[rd_ptr_q].age == '0);
    assign head_data = entry_q[rd_ptr_q].data;

endmodule

// File: rtl/mem_latency_model.sv
// Bus-slave memory model with programmable wait states, pipelined in-order read returns and read-data injection.
// Latency: readValid rises L=max(cfgReadLatency,1) cycles after a read's acceptance edge.
// Backpressure: waitRequest (combinational) stalls cfgWaitCycles per request, and stalls reads while the return FIFO is full.
// Ports: clk, reset (async, active-high); read/write/bwe/address/d request; cfgWaitCycles/cfgReadLatency;
//        injectEn/injectData; waitRequest, readValid, q, protocolError (sticky read+write).
// Build option: define MEM_MODEL_STATE_EN to add the ramState port (live view of the whole memory).
module mem_latency_model
    import memModelPkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LATENCY_WIDTH   = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               read,
    input  logic                               write,
    input  logic [DATA_WIDTH/8-1:0]            bwe,
    input  logic [31:0]                        address,
    input  logic [DATA_WIDTH-1:0]              d,
    input  logic [LATENCY_WIDTH-1:0]           cfgWaitCycles,
    input  logic [LATENCY_WIDTH-1:0]           cfgReadLatency,
    input  logic                               injectEn,
    input  logic [DATA_WIDTH-1:0]              injectData,
    output logic                               waitRequest,
    output logic                               readValid,
    output logic [DATA_WIDTH-1:0]              q,
    output logic                               protocolError
`ifdef MEM_MODEL_STATE_EN
    ,
    output logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] ramState
`endif
);
    localparam int NUM_BYTES = bytes_per_word(DATA_WIDTH);
    localparam int DEPTH     = 2**ADDR_WIDTH;
    localparam int CNT_W     = $clog2(MAX_OUTSTANDING) + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                   state_q, state_d;
    logic [LATENCY_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                     read_valid_q, read_valid_d;
    logic [DATA_WIDTH-1:0]    q_q, q_d;
    logic                     protocol_error_q, protocol_error_d;

    logic                     req;
    logic                     rd_op;
    logic                     rd_blocked;
    logic                     wait_req;
    logic                     accept;
    logic [ADDR_WIDTH-1:0]    idx;
    logic [LATENCY_WIDTH-1:0] push_age;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CNT_W-1:0]         fifo_count;
    logic                     head_vld;
    logic [DATA_WIDTH-1:0]    head_data;

    logic unused_in;
    assign unused_in = ^{address[31:ADDR_WIDTH+2], address[1:0], fifo_empty, fifo_count};

    assign req   = read | write;
    // read+write together is treated as a write; the read half is dropped.
    assign rd_op = read & ~write;
    // Full check uses the registered count: a pop in this cycle does not free
    // the slot until the next cycle.
    assign rd_blocked = rd_op & fifo_full;
    assign idx        = address[ADDR_WIDTH+1:2];

    // Wait-state FSM: N>0 wait cycles are IDLE (load N-1) plus N-1 STALL cycles.
    always_comb begin
        wait_req    = 1'b0;
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        if (!req) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfgWaitCycles != '0) begin
                        wait_req    = 1'b1;
                        state_d     = STALL;
                        stall_cnt_d = cfgWaitCycles - LATENCY_WIDTH'(1);
                    end else begin
                        wait_req = rd_blocked;
                    end
                end
                STALL: begin
                    if (stall_cnt_q != '0) begin
                        wait_req    = 1'b1;
                        stall_cnt_d = stall_cnt_q - LATENCY_WIDTH'(1);
                    end else begin
                        // Waits out a full FIFO here with the count at zero.
                        wait_req = rd_blocked;
                        if (!rd_blocked) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign waitRequest = wait_req;
    assign accept      = req & ~wait_req;

    // Stored age is L-1 so that the pop decided in the cycle after age hits
    // zero lands readValid exactly L edges after acceptance.
    assign push_age = (cfgReadLatency == '0) ? '0 : cfgReadLatency - LATENCY_WIDTH'(1);

    read_return_fifo #(
        .DATA_WIDTH      (DATA_WIDTH),
        .LATENCY_WIDTH   (LATENCY_WIDTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (accept & rd_op),
        .push_data (injectEn ? injectData : mem[idx]),
        .push_age  (push_age),
        .pop       (head_vld),
        .head_vld  (head_vld),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        read_valid_d     = head_vld;
        q_d              = head_vld ? head_data : q_q;
        protocol_error_d = protocol_error_q | (read & write);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            stall_cnt_q      <= '0;
            read_valid_q     <= 1'b0;
            q_q              <= '0;
            protocol_error_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            stall_cnt_q      <= stall_cnt_d;
            read_valid_q     <= read_valid_d;
            q_q              <= q_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    assign readValid     = read_valid_q;
    assign q             = q_q;
    assign protocolError = protocol_error_q;

    // Memory is deliberately outside reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (accept && write) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (bwe[k]) begin
                    mem[idx][k*BYTE_W +: BYTE_W] <= d[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

`ifdef MEM_MODEL_STATE_EN
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ramState[i] = mem[i];
        end
    end
`endif

endmodule

// File: tb/tb_mem_latency_model.sv
module tb_mem_latency_model;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int MO = 4;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [3:0]    bwe = '0;
    logic [31:0]   address = '0;
    logic [DW-1:0] d = '0;
    logic [LW-1:0] cfgWaitCycles = '0;
    logic [LW-1:0] cfgReadLatency = 3'd1;
    logic          injectEn = 1'b0;
    logic [DW-1:0] injectData = '0;
    logic          waitRequest;
    logic          readValid;
    logic [DW-1:0] q;
    logic          protocolError;
`ifdef MEM_MODEL_STATE_EN
    logic [2**AW-1:0][DW-1:0] ram_state;
`endif

    mem_latency_model #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MO),
        .LATENCY_WIDTH   (LW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .read           (read),
        .write          (write),
        .bwe            (bwe),
        .address        (address),
        .d              (d),
        .cfgWaitCycles  (cfgWaitCycles),
        .cfgReadLatency (cfgReadLatency),
        .injectEn       (injectEn),
        .injectData     (injectData),
        .waitRequest    (waitRequest),
        .readValid      (readValid),
        .q              (q),
        .protocolError  (protocolError)
`ifdef MEM_MODEL_STATE_EN
        ,
        .ramState       (ram_state)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Every readValid pulse is logged with the edge number that raised it.
    logic [DW-1:0] rv_data[$];
    int            rv_cyc[$];
    always @(negedge clk) begin
        if (readValid) begin
            rv_data.push_back(q);
            rv_cyc.push_back(cyc);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_returns();
        rv_data.delete();
        rv_cyc.delete();
    endtask

    // Holds a request until accepted; reports wait cycles and acceptance edge.
    task automatic bus_req(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] be, input logic inj, input logic [DW-1:0] inj_data,
                           output int waits, output int acc_edge);
        logic accepted;
        accepted   = 1'b0;
        read       = rd;
        write      = wr;
        address    = addr;
        d          = data;
        bwe        = be;
        injectEn   = inj;
        injectData = inj_data;
        waits      = 0;
        acc_edge   = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!waitRequest) begin
                accepted = 1'b1;
                acc_edge = cyc + 1;
                break;
            end
            waits++;
        end
        check({tag, "_accepted"}, accepted, 1'b1);
        @(posedge clk);
        #1;
        read     = 1'b0;
        write    = 1'b0;
        injectEn = 1'b0;
        bwe      = '0;
    endtask

    task automatic wait_returns(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && rv_data.size() < n; i++) step(1);
        step(3);
        check({tag, "_count"}, rv_data.size(), n);
    endtask

    task automatic check_ret(input string tag, input int i, input logic [DW-1:0] exp_data, input int exp_cyc);
        if (rv_data.size() > i) begin
            check({tag, "_q"}, rv_data[i], exp_data);
            check({tag, "_edge"}, rv_cyc[i], exp_cyc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        int a;
        int acc[5];
        int waits5[5];
        logic [DW-1:0] exp5[5];

        // Reset state
        step(3);
        check("rst_readValid", readValid, 1'b0);
        check("rst_q", q, '0);
        check("rst_protocolError", protocolError, 1'b0);
        check("rst_waitRequest", waitRequest, 1'b0);
        reset = 1'b0;
        step(1);

        // Full-word write then read, no waits, latency 1
        cfgWaitCycles  = 3'd0;
        cfgReadLatency = 3'd1;
        bus_req("wr10", 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, '0, w, a);
        check("wr10_waits", w, 0);
        clear_returns();
        bus_req("rd10", 1, 0, 32'h10, '0, 4'h0, 0, '0, w, a);
        check("rd10_waits", w, 0);
        wait_returns("rd10", 1, 20);
        check_ret("rd10", 0, 32'hDEADBEEF, a + 1);
        check("q_hold_data", q, 32'hDEADBEEF);
        check("q_hold_valid", readValid, 1'b0);

        // Byte-lane write merges into existing word
        bus_req("wrb1", 0, 1, 32'h10, 32'h0000AB00, 4'b0010, 0, '0, w, a);
        clear_returns();
        bus_req("rdb1", 1, 0, 32'h10, '0, 4'h0, 0, '0, w, a);
        wait_returns("rdb1", 1, 20);
        check_ret("rdb1", 0, 32'hDEADABEF, a + 1);

        // Three wait states with the read held
        cfgWaitCycles = 3'd3;
        clear_returns();
        bus_req("rdw3", 1, 0, 32'h10, '0, 4'h0, 0, '0, w, a);
        check("rdw3_waits", w, 3);
        wait_returns("rdw3", 1, 20);
        check_ret("rdw3", 0, 32'hDEADABEF, a + 1);

        // Read dropped after one stalled cycle: no access, FSM back to idle
        clear_returns();
        read    = 1'b1;
        address = 32'h10;
        @(negedge clk);
        check("drop_wait_hi", waitRequest, 1'b1);
        @(posedge clk);
        #1;
        read = 1'b0;
        #1;
        check("drop_wait_lo", waitRequest, 1'b0);
        wait_returns("drop", 0, 10);
        bus_req("rd_after_drop", 1, 0, 32'h10, '0, 4'h0, 0, '0, w, a);
        check("rd_after_drop_waits", w, 3);
        wait_returns("rd_after_drop", 1, 20);

        // Full FIFO: four reads in flight, fifth waits for the first pop
        cfgWaitCycles = 3'd0;
        bus_req("pre0", 0, 1, 32'h00, 32'h11111111, 4'hF, 0, '0, w, a);
        bus_req("pre4", 0, 1, 32'h04, 32'h22222222, 4'hF, 0, '0, w, a);
        bus_req("pre8", 0, 1, 32'h08, 32'h33333333, 4'hF, 0, '0, w, a);
        bus_req("preC", 0, 1, 32'h0C, 32'h44444444, 4'hF, 0, '0, w, a);
        exp5 = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'hDEADABEF};
        cfgReadLatency = 3'd7;
        clear_returns();
        for (int i = 0; i < 5; i++) begin
            bus_req($sformatf("full_rd%0d", i), 1, 0, 32'(i * 4), '0, 4'h0, 0, '0, waits5[i], acc[i]);
        end
        check("full_rd3_waits", waits5[3], 0);
        check("full_rd4_waits", waits5[4], 4);
        check("full_rd4_edge", acc[4], acc[0] + 8);
        wait_returns("full", 5, 40);
        for (int i = 0; i < 4; i++) begin
            check_ret($sformatf("full_ret%0d", i), i, exp5[i], acc[0] + i + 7);
        end
        check_ret("full_ret4", 4, exp5[4], acc[0] + 15);

        // Injection replaces the returned data but not memory
        cfgReadLatency = 3'd2;
        bus_req("wr20", 0, 1, 32'h20, 32'hCAFEF00D, 4'hF, 0, '0, w, a);
        clear_returns();
        bus_req("inj20", 1, 0, 32'h20, '0, 4'h0, 1, 32'h12345678, w, a);
        wait_returns("inj20", 1, 20);
        check_ret("inj20", 0, 32'h12345678, a + 2);
        clear_returns();
        bus_req("rd20", 1, 0, 32'h20, '0, 4'h0, 0, '0, w, a);
        wait_returns("rd20", 1, 20);
        check_ret("rd20", 0, 32'hCAFEF00D, a + 2);

        // Reset with two reads outstanding flushes them; memory survives
        cfgReadLatency = 3'd7;
        clear_returns();
        bus_req("rst_rd0", 1, 0, 32'h00, '0, 4'h0, 0, '0, w, a);
        bus_req("rst_rd4", 1, 0, 32'h04, '0, 4'h0, 0, '0, w, a);
        reset = 1'b1;
        #1;
        check("rst2_q", q, '0);
        step(2);
        reset = 1'b0;
        wait_returns("rst_flush", 0, 15);
        check("rst2_readValid", readValid, 1'b0);
        cfgReadLatency = 3'd0;
        clear_returns();
        bus_req("post_rst_rd4", 1, 0, 32'h04, '0, 4'h0, 0, '0, w, a);
        wait_returns("post_rst_rd4", 1, 20);
        check_ret("post_rst_rd4", 0, 32'h22222222, a + 1);

        // read and write together: write wins, error is sticky until reset
        clear_returns();
        bus_req("rdwr30", 1, 1, 32'h30, 32'hA5A5A5A5, 4'hF, 0, '0, w, a);
        check("rdwr30_err", protocolError, 1'b1);
        wait_returns("rdwr30", 0, 10);
        bus_req("rd30", 1, 0, 32'h30, '0, 4'h0, 0, '0, w, a);
        wait_returns("rd30", 1, 20);
        check_ret("rd30", 0, 32'hA5A5A5A5, a + 1);
        check("err_sticky", protocolError, 1'b1);
        reset = 1'b1;
        step(1);
        check("err_cleared", protocolError, 1'b0);
        reset = 1'b0;
        step(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
